// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and helpers for the reset sequencer.
//   - state_t      : sequencer FSM states
//   - LOST_CNT_W   : width of the saturating lock-loss counter
//   - cnt_width()  : width of the shared hold/gap cycle counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // One counter serves both the hold period and the inter-channel gap. It
  // only ever counts up to (max-1), so $clog2(max)+1 leaves headroom and the
  // terminal compare can never be skipped by a wrap.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int longest;
    longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Generic single-bit multi-flop synchroniser with asynchronous active-high
//   clear. Brings an asynchronous level into the clk domain.
//
//   Parameters
//     STAGES : number of flops in the chain (>= 2)
//   Ports
//     clk_i  : destination clock
//     rst_i  : asynchronous active-high clear (all stages to 0)
//     d_i    : asynchronous input level
//     q_o    : synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq
//   Reset sequencer. Watches the clock wizard's asynchronous lock, filters it,
//   holds every domain in reset for HOLD_CYCLES after lock is accepted and then
//   releases NUM_CH active-low channel resets one by one (channel 0 first),
//   STAGE_GAP cycles apart. Loss of lock drops everything back into reset and
//   is counted; a software request restarts the sequence from the hold phase.
//
//   Parameters
//     NUM_CH      : number of sequenced reset outputs (1..16)
//     SYNC_STAGES : flops on the lock synchroniser (>= 2)
//     LOCK_FILT   : consecutive synchronised-high cycles to accept lock (>= 1)
//     HOLD_CYCLES : cycles in HOLD before channel 0 releases (>= 1)
//     STAGE_GAP   : cycles between successive channel releases (>= 1)
//   Ports
//     clk           : system clock
//     rst           : asynchronous active-high reset
//     locked        : clock wizard lock, asynchronous to clk
//     sw_rst_req    : single-cycle software reset request (synchronous)
//     ch_rst_n      : per-channel active-low resets (registered)
//     ready         : high when every channel is released (registered)
//     lock_lost_cnt : saturating count of lock-loss events
//     dbg_state     : current sequencer state, for observation only
// -----------------------------------------------------------------------------
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  sw_rst_req,
  output logic [NUM_CH-1:0]     ch_rst_n,
  output logic                  ready,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output state_t                dbg_state
);

  localparam int CNT_W  = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int IDX_W  = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Lock synchroniser: nothing below looks at `locked` directly.
  // ---------------------------------------------------------------------------
  logic lk_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (lk_s)
  );

  // ---------------------------------------------------------------------------
  // Lock filter: rising direction needs LOCK_FILT consecutive highs, falling
  // direction clears at once.
  // ---------------------------------------------------------------------------
  logic [FILT_W-1:0] filt_q, filt_d;
  logic              lock_ok;

  always_comb begin
    filt_d = filt_q;
    if (!lk_s) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + FILT_W'(1);
    end
  end

  assign lock_ok = (filt_q == FILT_MAX);

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_CH-1:0]     ch_q, ch_d;
  logic                  ready_q, ready_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;

  // One-hot of the channel due for release next.
  logic [NUM_CH-1:0] idx_onehot;

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    case (state_q)
      WAIT_LOCK: begin
        ch_d    = '0;
        ready_d = 1'b0;
        if (lock_ok) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        ch_d    = '0;
        ready_d = 1'b0;
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          if (lost_q != '1) begin
            lost_d = lost_q + LOST_CNT_W'(1);
          end
        end else if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Channel 0 leaves reset on the same edge the hold period ends.
          ch_d[0] = 1'b1;
          cnt_d   = '0;
          if (NUM_CH == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          ch_d    = '0;
          ready_d = 1'b0;
          if (lost_q != '1) begin
            lost_d = lost_q + LOST_CNT_W'(1);
          end
        end else if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          ch_d    = '0;
          ready_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          // Already-released channels stay released; add the next one.
          cnt_d = '0;
          ch_d  = ch_q | idx_onehot;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        ch_d    = '1;
        ready_d = 1'b1;
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          ch_d    = '0;
          ready_d = 1'b0;
          if (lost_q != '1) begin
            lost_d = lost_q + LOST_CNT_W'(1);
          end
        end else if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          ch_d    = '0;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        ch_d    = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q  <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      ready_q <= 1'b0;
      lost_q  <= '0;
    end else begin
      filt_q  <= filt_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  assign ch_rst_n      = ch_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int GAP  = 8;
  localparam int NCH0 = 4;
  localparam int HLD0 = 16;
  localparam int NCH1 = 1;
  localparam int HLD1 = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       locked0 = 1'b0, sw0 = 1'b0;
  logic       locked1 = 1'b0, sw1 = 1'b0;
  logic [3:0] ch0;
  logic       rdy0;
  logic [7:0] lost0;
  state_t     st0;
  logic [0:0] ch1;
  logic       rdy1;
  logic [7:0] lost1;
  state_t     st1;

  rst_seq dut0 (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked0),
    .sw_rst_req    (sw0),
    .ch_rst_n      (ch0),
    .ready         (rdy0),
    .lock_lost_cnt (lost0),
    .dbg_state     (st0)
  );

  rst_seq #(
    .NUM_CH      (NCH1),
    .HOLD_CYCLES (HLD1)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked1),
    .sw_rst_req    (sw1),
    .ch_rst_n      (ch1),
    .ready         (rdy1),
    .lock_lost_cnt (lost1),
    .dbg_state     (st1)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: "active" means lock was accepted and a sequence is
  // running; t counts edges since the sequence (re)started. Released channel
  // count follows directly from t: channel k is out once t >= HOLD + k*GAP.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] sh;
    int          run;
    bit          active;
    int          t;
    int          lost;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.sh = '0; m.run = 0; m.active = 1'b0; m.t = 0; m.lost = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int nch, int hold, logic lk, logic sw);
    model_t n;
    logic   lks;
    n   = m;
    lks = m.sh[SYNC-1];
    if (m.active) begin
      if (!lks) begin
        n.active = 1'b0;
        if (m.lost < 255) n.lost = m.lost + 1;
      end else if (sw) begin
        n.t = 0;
      end else if (m.t < hold + nch * GAP) begin
        n.t = m.t + 1;
      end
    end else if (m.run == FILT) begin
      n.active = 1'b1;
      n.t      = 0;
    end
    n.run = lks ? ((m.run < FILT) ? m.run + 1 : FILT) : 0;
    n.sh  = {m.sh[14:0], lk};
    return n;
  endfunction

  function automatic int released(model_t m, int nch, int hold);
    int n;
    if (!m.active || m.t < hold) return 0;
    n = 1 + (m.t - hold) / GAP;
    return (n > nch) ? nch : n;
  endfunction

  function automatic logic [12:0] exp_word0(model_t m);
    int   n;
    logic [3:0] mask;
    n    = released(m, NCH0, HLD0);
    mask = 4'((1 << n) - 1);
    return {8'(m.lost), (n == NCH0), mask};
  endfunction

  function automatic logic [9:0] exp_word1(model_t m);
    int n;
    n = released(m, NCH1, HLD1);
    return {8'(m.lost), (n == NCH1), (n == NCH1)};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: model advances on each edge, checked half a cycle later.
  // ---------------------------------------------------------------------------
  model_t      m0, m1;
  logic [12:0] exp_q0[$];
  logic [9:0]  exp_q1[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = model_reset();
      m1 = model_reset();
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      m0 = model_step(m0, NCH0, HLD0, locked0, sw0);
      m1 = model_step(m1, NCH1, HLD1, locked1, sw1);
      exp_q0.push_back(exp_word0(m0));
      exp_q1.push_back(exp_word1(m1));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q0.size() > 0) check_eq("dut0_out", {19'd0, lost0, rdy0, ch0}, {19'd0, exp_q0.pop_front()});
      if (exp_q1.size() > 0) check_eq("dut1_out", {22'd0, lost1, rdy1, ch1}, {22'd0, exp_q1.pop_front()});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int         r_ch[4];
  int         r_rdy, r1_ch, r1_rdy;
  logic [3:0] s_ch;
  logic       s_rdy;
  logic [7:0] s_lost;

  // Counts edges from the next posedge (edge 0) and records the first rising
  // edge of each output, plus a snapshot of dut0 at edge snap_e.
  task automatic measure(input bit pulse_sw, input int snap_e);
    logic [3:0] pch;
    logic       prdy, p1ch, p1rdy;
    pch = ch0; prdy = rdy0; p1ch = ch1[0]; p1rdy = rdy1;
    for (int k = 0; k < 4; k++) r_ch[k] = -1;
    r_rdy = -1; r1_ch = -1; r1_rdy = -1;
    s_ch = 'x; s_rdy = 1'bx; s_lost = 'x;
    for (int e = 0; e < 120; e++) begin
      @(posedge clk);
      #1;
      if (pulse_sw && e == 0) sw0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (ch0[k] && !pch[k] && r_ch[k] < 0) r_ch[k] = e;
      end
      if (rdy0 && !prdy && r_rdy < 0) r_rdy = e;
      if (ch1[0] && !p1ch && r1_ch < 0) r1_ch = e;
      if (rdy1 && !p1rdy && r1_rdy < 0) r1_rdy = e;
      if (e == snap_e) begin
        s_ch = ch0; s_rdy = rdy0; s_lost = lost0;
      end
      pch = ch0; prdy = rdy0; p1ch = ch1[0]; p1rdy = rdy1;
    end
  endtask

  task automatic check_seq(input string tag, input int base);
    check_eq({tag, "_ch0_edge"}, r_ch[0], base);
    check_eq({tag, "_ch1_edge"}, r_ch[1], base + GAP);
    check_eq({tag, "_ch2_edge"}, r_ch[2], base + 2 * GAP);
    check_eq({tag, "_ch3_edge"}, r_ch[3], base + 3 * GAP);
    check_eq({tag, "_rdy_edge"}, r_rdy, base + 3 * GAP);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seg0, seg1;

    repeat (3) @(negedge clk);
    check_eq("rst_ch0", ch0, 0);
    check_eq("rst_rdy0", rdy0, 0);
    check_eq("rst_lost0", lost0, 0);
    check_eq("rst_ch1", ch1, 0);
    check_eq("rst_rdy1", rdy1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First lock: both instances.
    locked0 = 1'b1;
    locked1 = 1'b1;
    measure(1'b0, 0);
    check_seq("lock", SYNC + FILT + HLD0);
    check_eq("lock_dut1_ch_edge", r1_ch, SYNC + FILT + HLD1);
    check_eq("lock_dut1_rdy_edge", r1_rdy, SYNC + FILT + HLD1);
    check_eq("lock_lost", lost0, 0);

    // One-cycle lock drop while in RUN.
    @(negedge clk) locked0 = 1'b0;
    @(negedge clk) locked0 = 1'b1;
    measure(1'b0, 2);
    check_eq("drop_ch", s_ch, 0);
    check_eq("drop_rdy", s_rdy, 0);
    check_eq("drop_lost", s_lost, 1);
    check_seq("relock", SYNC + FILT + HLD0);

    // Software reset pulse while in RUN.
    @(negedge clk) sw0 = 1'b1;
    measure(1'b1, 0);
    check_eq("sw_ch", s_ch, 0);
    check_eq("sw_rdy", s_rdy, 0);
    check_seq("sw", HLD0);
    check_eq("sw_lost", lost0, 1);

    // Short lock glitch while in WAIT_LOCK.
    @(negedge clk) locked0 = 1'b0;
    repeat (8) @(negedge clk);
    locked0 = 1'b1;
    repeat (3) @(negedge clk);
    locked0 = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("glitch_ch", ch0, 0);
    check_eq("glitch_rdy", rdy0, 0);
    check_eq("glitch_lost", lost0, 2);

    // Many lock-loss events: counter saturates.
    for (int i = 0; i < 300; i++) begin
      locked0 = 1'b1;
      repeat (8) @(negedge clk);
      locked0 = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_eq("sat_lost", lost0, 255);

    // Asynchronous reset in the middle of RELEASE.
    locked0 = 1'b1;
    repeat (35) @(negedge clk);
    check_eq("pre_rst_ch", ch0, 4'h3);
    #2 rst = 1'b1;
    #1;
    check_eq("async_ch0", ch0, 0);
    check_eq("async_rdy0", rdy0, 0);
    check_eq("async_lost0", lost0, 0);
    check_eq("async_ch1", ch1, 0);
    check_eq("async_rdy1", rdy1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Randomised lock and software-request traffic on both instances.
    seg0 = 0;
    seg1 = 0;
    repeat (3000) begin
      @(negedge clk);
      if (seg0 == 0) begin
        locked0 = ($urandom_range(0, 9) < 7);
        seg0    = $urandom_range(1, 80);
      end
      if (seg1 == 0) begin
        locked1 = ($urandom_range(0, 9) < 7);
        seg1    = $urandom_range(1, 40);
      end
      seg0--;
      seg1--;
      sw0 = ($urandom_range(0, 19) == 0);
      sw1 = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    sw0 = 1'b0;
    sw1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Parametrised reset sequencer that supersedes the single-stage reset synchroniser in the FPGA wrapper. It monitors the clock wizard's asynchronous `locked` output, filters it and holds all domains in reset for a programmable time. It then releases NUM_CH active-low channel resets one at a time in a fixed order. It also handles lock loss and software-requested resets, and counts lock-loss events.

Parameters:
- NUM_CH, 4, number of sequenced reset outputs (1..16); channel 0 is released first.
- SYNC_STAGES, 2, flip-flop stages on the `locked` synchroniser (>=2).
- LOCK_FILT, 4, consecutive synchronised-high cycles required before lock is accepted (>=1).
- HOLD_CYCLES, 16, cycles all channels stay in reset after lock is accepted (>=1).
- STAGE_GAP, 8, cycles between successive channel releases (>=1).

Ports:
- clk  in  1  system clock (clock wizard output)
- rst  in  1  asynchronous, active-high reset
- locked  in  1  clock wizard lock, asynchronous to clk
- sw_rst_req  in  1  synchronous single-cycle software reset request
- ch_rst_n  out  NUM_CH  per-channel active-low resets, registered
- ready  out  1  high when all channels are released
- lock_lost_cnt  out  8  saturating count of lock-loss events

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All flops clear on `rst` assertion and are clocked on the `clk` rising edge.
- Reset values: ch_rst_n = all 0, ready = 0, lock_lost_cnt = 0, state = WAIT_LOCK, synchroniser and filter = 0.
- Synchroniser: `locked` passes through SYNC_STAGES flops to produce lk_s. All other logic uses only lk_s.
- Filter:
  - Counter increments while lk_s = 1 and saturates at LOCK_FILT.
  - Counter clears on the same edge that lk_s = 0 is seen.
  - lock_ok = (counter == LOCK_FILT).
  - Loss of lock acts immediately; there is no filter on the falling direction.
- States: WAIT_LOCK, HOLD, RELEASE, RUN. A single cycle counter is shared across HOLD and RELEASE, with a channel index in RELEASE.
- WAIT_LOCK: all channels asserted, ready = 0. When lock_ok, go to HOLD and clear the cycle counter.
- HOLD:
  - All channels asserted.
  - After HOLD_CYCLES cycles in HOLD, set ch_rst_n[0] = 1 on the same edge and enter RELEASE with index 1.
  - If NUM_CH = 1, enter RUN directly and set ready on that edge.
- RELEASE:
  - Every STAGE_GAP cycles, set ch_rst_n[index] = 1 and increment index.
  - On the edge that releases channel NUM_CH-1, enter RUN and set ready = 1 on that same edge.
  - Released channels stay released while in RELEASE/RUN.
- RUN: all ch_rst_n = 1, ready = 1.
- Lock loss (lk_s = 0 in HOLD, RELEASE or RUN):
  - On the next edge, all ch_rst_n go to 0 and ready goes to 0 simultaneously; state becomes WAIT_LOCK.
  - lock_lost_cnt increments and saturates at 255.
  - Lock loss is not counted while already in WAIT_LOCK.
- sw_rst_req = 1 with lk_s = 1:
  - In RELEASE or RUN: on the next edge all channels are asserted, ready = 0, go to HOLD with the counter cleared. lock_lost_cnt is unchanged.
  - In HOLD: restarts the hold counter.
  - In WAIT_LOCK: ignored.
- Simultaneous lock loss and sw_rst_req: lock loss wins (WAIT_LOCK, count increments).
- Release order is strictly ascending; channel k is never released while channel k-1 is asserted.
- Counter widths are sized by $clog2 of the max of HOLD_CYCLES and STAGE_GAP, plus 1. There must be no wrap-around before the terminal compare.
- Mid-sequence `rst` assertion returns every output to its reset value asynchronously.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum (WAIT_LOCK, HOLD, RELEASE, RUN);
  - the counter-width helper function;
  - the LOST_CNT_W = 8 constant.
- One sub-module, sync_ff: a generic SYNC_STAGES-deep single-bit synchroniser with async active-high clear. It is reused for `locked` and is available to other blocks.

Test Plan:
- Defaults, `rst` released, then `locked` rises and is first sampled at edge 0:
  - ch_rst_n[0] rises at edge 22 (2 + 4 + 16);
  - ch_rst_n[1] at 30, ch_rst_n[2] at 38, ch_rst_n[3] at 46;
  - ready rises at edge 46;
  - lock_lost_cnt stays 0.
- In RUN, `locked` drops for 1 clk → ch_rst_n = 4'b0000 and ready = 0 by edge SYNC_STAGES+1 after the drop, lock_lost_cnt = 1. The full sequence repeats with the same 22/30/38/46 offsets from the re-rise.
- `locked` glitches high for 3 cycles only, while in WAIT_LOCK → no state change, ch_rst_n stays 0, lock_lost_cnt stays 0.
- sw_rst_req pulse while in RUN → next edge ch_rst_n = 0 and ready = 0. ch_rst_n[0] re-releases 16 edges later and ready 40 edges later. lock_lost_cnt unchanged.
- 300 lock-loss events → lock_lost_cnt saturates at 255.
- NUM_CH = 1, HOLD_CYCLES = 3: ch_rst_n[0] and ready rise together 3 edges after lock_ok. `rst` asserted mid-RELEASE with NUM_CH = 4 clears all outputs immediately.
